bin_to_bcd_seq: RTL and testbench

//   Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble).

---
 rtl/bin_to_bcd_seq_pkg.sv | 22 ++
 rtl/bin_to_bcd_seq_if.sv | 37 +++
 rtl/bin_to_bcd_seq_digit_adj.sv | 16 +
 rtl/bin_to_bcd_seq.sv | 131 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq_pkg
//   Shared definitions for the sequential binary-to-BCD converter:
//   digit width, blank digit code and the FSM state encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package bin_to_bcd_seq_pkg;

    // Width of one packed BCD digit.
    localparam int BCD_DIGIT_W = 4;

    // Code that the 7-segment digit decoder shows as an unlit digit.
    localparam logic [BCD_DIGIT_W-1:0] BLANK_DIGIT = 4'hF;

    // Converter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : bin_to_bcd_seq_pkg

// File: rtl/bin_to_bcd_seq_if.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq_if
//   Request/result bundle of the binary-to-BCD converter.
//   Signals:
//     start    master->slave  request a conversion of bin
//     bin      master->slave  unsigned value, sampled on the accepted start cycle
//     busy     slave->master  conversion in progress
//     done     slave->master  one-cycle pulse, bcd/overflow updated this cycle
//     bcd      slave->master  packed BCD digits, [3:0] = units
//     overflow slave->master  last converted value exceeded 10**DIGITS-1
//
//   Handshake: start acts as a valid and !busy as the ready. A conversion is
//   accepted on a rising edge where start=1 and busy=0; start while busy=1 is
//   dropped (not queued). Completion is the single-cycle done pulse; bcd and
//   overflow hold their value until the next done.
// -----------------------------------------------------------------------------
interface bin_to_bcd_seq_if #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
);
    logic                  start;
    logic [BIN_WIDTH-1:0]  bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow
    );
endinterface : bin_to_bcd_seq_if

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq_digit_adj
//   Combinational double-dabble digit correction: a BCD digit of 5 or more
//   gets +3 so that the following left shift carries into the next digit.
//   Ports:
//     digit_i  in  4  scratch digit before the shift
//     digit_o  out 4  corrected digit
// -----------------------------------------------------------------------------
module bin_to_bcd_seq_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);
    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;
endmodule : bin_to_bcd_seq_digit_adj

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter (shift-add-3). One bit of the input is
//   shifted into the BCD scratch register per cycle; the visible result is
//   updated atomically together with the done pulse so the driven displays
//   never see intermediate digits.
//   Ports:
//     clk      in   clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     conv     slave modport of bin_to_bcd_seq_if (start/bin/busy/done/bcd/overflow)
//     state_o  out  current FSM state (debug)
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4,
    parameter bit BLANK_LZ  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bin_to_bcd_seq_if.slave       conv,
    output state_t                state_o
);
    localparam int          SW      = BCD_DIGIT_W * DIGITS;
    localparam int          CW      = $clog2(BIN_WIDTH + 1);
    localparam logic [31:0] MAX_VAL = 32'(10**DIGITS - 1);

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [BIN_WIDTH-1:0] shreg_q;
    logic [SW-1:0]        scratch_q;
    logic                 ovf_pend_q;
    logic                 busy_q;
    logic                 done_q;
    logic [SW-1:0]        bcd_q;
    logic                 overflow_q;

    logic [SW-1:0]        scratch_adj;
    logic [SW-1:0]        scratch_d;
    logic [SW-1:0]        blanked;
    logic [SW-1:0]        bcd_d;

    // Add-3 correction on every digit in parallel.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bin_to_bcd_seq_digit_adj u_adj (
            .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Shift left by one; the top scratch bit is dropped (overflow is already
    // known from the latch-time compare).
    assign scratch_d = {scratch_adj[SW-2:0], shreg_q[BIN_WIDTH-1]};

    // Leading-zero blanking of the value that is about to become visible.
    always_comb begin : blank_lz
        logic leading;
        blanked = scratch_d;
        leading = 1'b1;
        if (BLANK_LZ) begin
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (leading && (scratch_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0)) begin
                    blanked[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BLANK_DIGIT;
                end else begin
                    leading = 1'b0;
                end
            end
        end
    end

    assign bcd_d = ovf_pend_q ? {DIGITS{BLANK_DIGIT}} : blanked;

    // The final shift edge loads the output registers directly from the
    // combinational next scratch, so done and the new bcd appear together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            scratch_q  <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (conv.start) begin
                        shreg_q    <= conv.bin;
                        scratch_q  <= '0;
                        cnt_q      <= CW'(BIN_WIDTH);
                        ovf_pend_q <= (32'(conv.bin) > MAX_VAL);
                        busy_q     <= 1'b1;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch_q <= scratch_d;
                    shreg_q   <= shreg_q << 1;
                    cnt_q     <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        done_q     <= 1'b1;
                        bcd_q      <= bcd_d;
                        overflow_q <= ovf_pend_q;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign conv.busy     = busy_q;
    assign conv.done     = done_q;
    assign conv.bcd      = bcd_q;
    assign conv.overflow = overflow_q;
    assign state_o       = state_q;

endmodule : bin_to_bcd_seq

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//   Drives two converters (leading zeros kept / blanked) with identical
//   stimulus and compares them with a decimal reference model.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;
    import bin_to_bcd_seq_pkg::*;

    localparam int BW  = 14;
    localparam int DG  = 4;
    localparam int LAT = BW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start;
    logic [BW-1:0] bin;
    state_t        st0, st1;

    bin_to_bcd_seq_if #(.BIN_WIDTH(BW), .DIGITS(DG)) if0 ();
    bin_to_bcd_seq_if #(.BIN_WIDTH(BW), .DIGITS(DG)) if1 ();

    assign if0.start = start;
    assign if0.bin   = bin;
    assign if1.start = start;
    assign if1.bin   = bin;

    bin_to_bcd_seq #(.BIN_WIDTH(BW), .DIGITS(DG), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .conv(if0), .state_o(st0)
    );
    bin_to_bcd_seq #(.BIN_WIDTH(BW), .DIGITS(DG), .BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .conv(if1), .state_o(st1)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [4*DG-1:0] exp0_q[$];
    logic [4*DG-1:0] exp1_q[$];
    int done_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Decimal reference: digits by division, blank code for out-of-range,
    // leading zeros blanked from the top down to digit 1.
    function automatic logic [4*DG-1:0] model(input int v, input bit blank);
        int d[DG];
        logic [4*DG-1:0] r;
        if (v > 10**DG - 1) return {DG{4'hF}};
        for (int i = 0; i < DG; i++) d[i] = (v / (10**i)) % 10;
        if (blank) begin
            for (int i = DG - 1; i >= 1; i--) begin
                if (d[i] != 0) break;
                d[i] = 15;
            end
        end
        r = '0;
        for (int i = 0; i < DG; i++) r[i*4 +: 4] = 4'(d[i]);
        return r;
    endfunction

    // ---------------- driver ----------------
    // Entered and left on a falling edge. Starts one conversion after `gap`
    // idle cycles and checks latency, result and busy release.
    task automatic run_conv(input int v, input int gap);
        int lat;
        bit got;
        logic [4*DG-1:0] e0, e1;
        repeat (gap) @(negedge clk);
        start = 1'b1;
        bin   = BW'(v);
        exp0_q.push_back(model(v, 1'b0));
        exp1_q.push_back(model(v, 1'b1));
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = BW'($urandom_range(0, 16383));
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check("busy_rise", {31'b0, if0.busy}, 32'd1);
            if (if0.done) got = 1'b1;
        end
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
            void'(exp0_q.pop_front());
            void'(exp1_q.pop_front());
        end else begin
            done_cyc = cyc;
            e0 = exp0_q.pop_front();
            e1 = exp1_q.pop_front();
            check("latency", 32'(lat), 32'(LAT));
            check("done_lz", {31'b0, if1.done}, 32'd1);
            check("busy_at_done", {31'b0, if0.busy}, 32'd1);
            check("bcd", 32'(if0.bcd), 32'(e0));
            check("bcd_lz", 32'(if1.bcd), 32'(e1));
            check("ovf", {31'b0, if0.overflow}, {31'b0, (v > 10**DG - 1)});
            check("ovf_lz", {31'b0, if1.overflow}, {31'b0, (v > 10**DG - 1)});
            @(negedge clk);
            check("done_fall", {31'b0, if0.done}, 32'd0);
            check("busy_fall", {31'b0, if0.busy}, 32'd0);
        end
    endtask

    // Counts done pulses over n cycles, starting and ending on a falling edge.
    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (if0.done || if1.done) cnt++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d1, cnt, ndone;
        bit stable;
        logic [4*DG-1:0] prev;
        start = 1'b0;
        bin   = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bcd", 32'(if0.bcd), 32'h0);
        check("rst_bcd_lz", 32'(if1.bcd), 32'h0);
        check("rst_busy", {31'b0, if0.busy}, 32'd0);
        check("rst_done", {31'b0, if0.done}, 32'd0);
        check("rst_ovf", {31'b0, if0.overflow}, 32'd0);
        check("rst_state", 32'(st0), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed values, including range boundaries and blanking cases.
        run_conv(1234, 1);
        run_conv(9999, 1);
        run_conv(10000, 2);
        run_conv(16383, 0);
        run_conv(7, 1);
        run_conv(0, 1);
        run_conv(1005, 1);
        run_conv(40, 1);

        // Start while busy is dropped; bcd holds until the single done.
        prev  = if0.bcd;
        start = 1'b1;
        bin   = BW'(55);
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = BW'(99);
        stable = 1'b1;
        cnt = 0;
        ndone = 0;
        while (ndone == 0 && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (cnt == 5) begin
                start = 1'b1;
                bin   = BW'(77);
            end else begin
                start = 1'b0;
            end
            if (if0.done) ndone++;
            else if (if0.bcd !== prev) stable = 1'b0;
        end
        start = 1'b0;
        check("ign_stable", {31'b0, stable}, 32'd1);
        check("ign_latency", 32'(cnt), 32'(LAT));
        check("ign_bcd", 32'(if0.bcd), 32'(model(55, 1'b0)));
        check("ign_bcd_lz", 32'(if1.bcd), 32'(model(55, 1'b1)));
        count_dones(40, cnt);
        check("ign_extra_done", 32'(cnt), 32'd0);

        // Back-to-back starts.
        run_conv(321, 1);
        d1 = done_cyc;
        run_conv(654, 0);
        check("b2b_spacing", 32'(done_cyc - d1), 32'(BW + 2));

        // Randomized values, biased around the overflow boundary.
        for (int i = 0; i < 30; i++) begin
            int v;
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9990, 10010))
                                            : int'($urandom_range(0, 16383));
            run_conv(v, int'($urandom_range(0, 3)));
        end

        // Make sure bcd is non-zero before the abort so the reset is visible.
        run_conv(8765, 1);
        start = 1'b1;
        bin   = BW'(4321);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_bcd", 32'(if0.bcd), 32'h0);
        check("abort_busy", {31'b0, if0.busy}, 32'd0);
        check("abort_ovf", {31'b0, if0.overflow}, 32'd0);
        check("abort_done", {31'b0, if0.done}, 32'd0);
        check("abort_state", 32'(st0), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(30, cnt);
        check("abort_no_done", 32'(cnt), 32'd0);
        check("abort_bcd_hold", 32'(if0.bcd), 32'h0);

        // Converter is usable again after the abort.
        run_conv(4321, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        n_checks++;
        n_errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_bin_to_bcd_seq
